disp_arbiter: RTL
=================

DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, 50_000_000, minimum ownership slice in clk cycles before a waiting requester may preempt (range 1..2^32-1).
REQ-002 Parameter GAP_CYCLES, 2, blanking cycles inserted between owners (range 1..255).
REQ-003 Parameter BLANK, 8'hFF, segment pattern driven on every digit when no owner (active-low segments, all off).
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  level request per requester; held high while requester wants the display.
REQ-007 frame0..frame3  input  64 each  requester digit patterns; digit k = bits [8k+7:8k].
REQ-008 gnt  output  4  one-hot registered grant; all-zero when no owner.
REQ-009 busy  output  1  high in OWN state.
REQ-010 in0..in7  output  8 each  registered digit patterns for the 8-digit LED multiplexer (in k = digit k).

Function
REQ-011 FSM states IDLE, OWN, GAP; state, gnt, slice counter, gap counter, last-owner pointer all registered.
REQ-012 IDLE: if any req bit high, select owner by round-robin starting at last_owner+1 (mod 4); next cycle state=OWN, gnt=onehot(owner), last_owner=owner, slice counter=0.
REQ-013 OWN: slice counter increments each cycle, saturating at HOLD_CYCLES-1.
REQ-014 OWN, owner req low: next cycle state=GAP, gnt=0 (release latency 1 cycle).
REQ-015 OWN, counter==HOLD_CYCLES-1 and any other req high: next cycle state=GAP, gnt=0 (preemption).
REQ-016 OWN, counter saturated, no other req: remain OWN indefinitely.
REQ-017 GAP: lasts exactly GAP_CYCLES cycles with gnt=0; on final cycle arbitrate as in IDLE, entering OWN directly if any req high, else IDLE.
REQ-018 Requester just released is eligible again only after all other pending requesters in round-robin order.
REQ-019 in0..in7 = frame[owner] digits registered each cycle in OWN (1-cycle latency from frame change); BLANK on all digits in IDLE and GAP.
REQ-020 Simultaneous owner release and slice expiry: treat as release (REQ-014).
REQ-021 req bits changing during GAP affect only the arbitration on GAP's final cycle.

Reset
REQ-022 rst_n low asynchronously forces state=IDLE, gnt=0, busy=0, counters=0, last_owner=3, in0..in7=BLANK.
REQ-023 Reset asserted mid-OWN or mid-GAP discards ownership; first grant after release goes to lowest-index requesting bit from 0.

Configuration
REQ-024 Macro DISP_ARB_PRIO_EN defined: requester 0 is high priority -- arbitration selects 0 whenever req[0] high, and req[0] rising while another owns forces GAP next cycle regardless of slice counter.
REQ-025 Macro undefined: pure round-robin per REQ-012..REQ-018; requester 0 has no precedence.

Structure
REQ-026 Package disp_arb_pkg holds state enum type, N_REQ=4 constant, default BLANK constant.
REQ-027 One sub-module rr_pick: combinational 4-way round-robin picker (req, last_owner -> owner index, valid); instantiated once.

Verification (HOLD_CYCLES=8, GAP_CYCLES=2)
REQ-028 Reset release, req=4'b0100 at cycle 0 -> gnt=4'b0100 at cycle 1, in0..in7=frame2 digits from cycle 2.
REQ-029 Owner 2 holds, req[0] rises at cycle 3 -> gnt=0 after counter reaches 7 (cycle 9), gnt=4'b0001 after 2 blank cycles, in0..in7=8'hFF during gap.
REQ-030 req=4'b1111 sustained -> grant order 0,1,2,3,0 with 8-cycle slices and 2-cycle gaps.
REQ-031 Owner drops req at slice cycle 3, no others -> GAP 2 cycles, then IDLE, busy=0, outputs BLANK.
REQ-032 rst_n pulsed low mid-OWN -> gnt=0, outputs BLANK immediately; after release req=4'b1010 grants requester 1.
REQ-033 With DISP_ARB_PRIO_EN, owner 3 at slice cycle 2, req[0] rises -> gnt=0 next cycle, gnt=4'b0001 after gap.

Source files
------------

// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display arbiter: state encoding,
// requester count, default blank segment pattern and a one-hot helper.
package disp_arb_pkg;

    localparam int N_REQ = 4;
    localparam int OWN_W = $clog2(N_REQ);
    localparam int N_DIG = 8;

    // Active-low segments: all ones turns every segment off.
    localparam logic [7:0] BLANK_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after i_last,
// wrapping, with i_last itself considered last.
module rr_pick
    import disp_arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [OWN_W-1:0] i_last,
    output logic [OWN_W-1:0] o_owner,
    output logic             o_valid
);

    always_comb begin
        logic [OWN_W-1:0] w_idx;
        w_idx   = i_last;
        o_owner = i_last;
        o_valid = |i_req;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = N_REQ; i >= 1; i--) begin
            w_idx = i_last + OWN_W'(i);
            if (i_req[w_idx]) o_owner = w_idx;
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// Time-sliced arbiter granting one of four requesters the 8-digit LED display.
// Optional macro DISP_ARB_PRIO_EN makes requester 0 high priority.
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000,
    parameter logic [7:0]  GAP_CYCLES  = 8'd2,
    parameter logic [7:0]  BLANK       = BLANK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] frame0,
    input  logic [63:0] frame1,
    input  logic [63:0] frame2,
    input  logic [63:0] frame3,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic [7:0]  in0,
    output logic [7:0]  in1,
    output logic [7:0]  in2,
    output logic [7:0]  in3,
    output logic [7:0]  in4,
    output logic [7:0]  in5,
    output logic [7:0]  in6,
    output logic [7:0]  in7
);

    arb_state_e              r_state;
    arb_state_e              w_nstate;
    logic [OWN_W-1:0]        r_last;
    logic [OWN_W-1:0]        w_pick;
    logic [OWN_W-1:0]        w_rr_pick;
    logic                    w_pick_vld;
    logic                    w_load_own;
    logic                    w_prio_pre;
    logic                    w_others;
    logic                    w_show;
    logic [N_REQ-1:0]        r_gnt;
    logic [31:0]             r_slice;
    logic [7:0]              r_gap;
    logic [N_REQ-1:0][63:0]  w_frames;
    logic [63:0]             w_sel;
    logic [N_DIG-1:0][7:0]   r_in;

    rr_pick u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_owner (w_rr_pick),
        .o_valid (w_pick_vld)
    );

`ifdef DISP_ARB_PRIO_EN
    logic r_req0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_req0_q <= 1'b0;
        else        r_req0_q <= req[0];
    end

    // A fresh req[0] evicts any other owner regardless of slice progress.
    assign w_prio_pre = req[0] & ~r_req0_q & (r_last != '0);
    assign w_pick     = req[0] ? '0 : w_rr_pick;
`else
    assign w_prio_pre = 1'b0;
    assign w_pick     = w_rr_pick;
`endif

    assign w_frames[0] = frame0;
    assign w_frames[1] = frame1;
    assign w_frames[2] = frame2;
    assign w_frames[3] = frame3;
    assign w_sel       = w_frames[r_last];
    assign w_others    = |(req & ~onehot(r_last));

    always_comb begin
        w_nstate   = r_state;
        w_load_own = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_nstate   = ST_OWN;
                    w_load_own = 1'b1;
                end
            end
            ST_OWN: begin
                if (!req[r_last])
                    w_nstate = ST_GAP;
                else if ((r_slice == HOLD_CYCLES - 32'd1) && w_others)
                    w_nstate = ST_GAP;
                else if (w_prio_pre)
                    w_nstate = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == GAP_CYCLES - 8'd1) begin
                    if (w_pick_vld) begin
                        w_nstate   = ST_OWN;
                        w_load_own = 1'b1;
                    end else begin
                        w_nstate = ST_IDLE;
                    end
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= OWN_W'(N_REQ - 1);
            r_gnt   <= '0;
            r_slice <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_load_own) begin
                r_last  <= w_pick;
                r_gnt   <= onehot(w_pick);
                r_slice <= '0;
            end else if (w_nstate == ST_OWN) begin
                if (r_slice != HOLD_CYCLES - 32'd1) r_slice <= r_slice + 32'd1;
            end else begin
                r_gnt   <= '0;
                r_slice <= '0;
            end
            r_gap <= (r_state == ST_GAP && w_nstate == ST_GAP) ? r_gap + 8'd1 : 8'd0;
        end
    end

    // Show the frame only while ownership continues, so the first GAP cycle is already blank.
    assign w_show = (r_state == ST_OWN) && (w_nstate == ST_OWN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_DIG; k++) r_in[k] <= BLANK;
        end else begin
            for (int k = 0; k < N_DIG; k++) r_in[k] <= w_show ? w_sel[8*k +: 8] : BLANK;
        end
    end

    assign gnt  = r_gnt;
    assign busy = (r_state == ST_OWN);
    assign in0  = r_in[0];
    assign in1  = r_in[1];
    assign in2  = r_in[2];
    assign in3  = r_in[3];
    assign in4  = r_in[4];
    assign in5  = r_in[5];
    assign in6  = r_in[6];
    assign in7  = r_in[7];

endmodule
